mdl_tempdet_mc: RTL
===================

// Module: mdl_tempdet_mc
// PURPOSE
//  Multi-channel successor of the single-loop temperature detector/heater control. Each channel
//  debounces its TEMPLO_n sensor and flags temperature drops. It drives a heater enable
//  sequenced by the 2MHz clock stop/restart and guarded by a heater-on watchdog.
//  Sits between the bubble-cartridge sense inputs and the main sequencer's TEMPDROP flag logic.
// PARAMETERS
//  CH      2      number of independent sensor/heater channels (1..8)
//  DB_LEN  8      debounce length, in CLK4M enable ticks (1..2**DB_W-1)
//  DB_W    4      debounce counter width
//  TMO     50000  heater watchdog limit, in CLK4M enable ticks (only with TEMPDET_WATCHDOG_EN)
//  TMO_W   16     watchdog counter width
// PORTS
//  i_MCLK               in   1   master clock; all flops on posedge
//  i_RST                in   1   asynchronous reset, active-high
//  i_CLK4M_PCEN_n       in   1   4MHz enable, active-low; every state update qualified by it
//  i_CLK2M_STOP_n       in   1   0 = 2MHz clock stopped; shared by all channels
//  i_CLK2M_STOP_DLYD_n  in   1   delayed copy of i_CLK2M_STOP_n
//  i_TEMPLO_n           in   CH  raw sensor per channel, 0 = temperature low
//  i_FAULT_CLR          in   1   synchronous clear of all sticky faults (on enable tick)
//  o_TEMPDROP_SET_n     out  CH  one-tick low pulse per detected drop
//  o_HEATEN_n           out  CH  heater enable, active-low
//  o_FAULT              out  CH  sticky watchdog fault
//  o_TEMPOK             out  1   1 when every channel's filtered sensor is high
// BEHAVIOUR
//  Tick: an MCLK edge with i_CLK4M_PCEN_n=0. Nothing changes on other edges.
//  Reset values: filt=1, db_cnt=0, state=OFF, wd=0, o_TEMPDROP_SET_n=all 1, o_HEATEN_n=all 1,
//  o_FAULT=0, o_TEMPOK=1. Reset may assert mid-heat; outputs go inactive immediately, asynchronously.
//  Debounce, per channel: if raw==filt then db_cnt<=0; else db_cnt++, and when db_cnt reaches
//   DB_LEN-1 then filt<=raw and db_cnt<=0. A glitch shorter than DB_LEN ticks is ignored.
//  gate = i_CLK2M_STOP_n & filt. gate_q is gate registered per tick; dly_q is STOP_DLYD_n registered.
//  Drop: o_TEMPDROP_SET_n registered <= ~(gate_q & ~gate). It is low for one tick, one tick after the fall.
//  clr = (~gate_q & gate) | ~i_CLK2M_STOP_n     (rise of gate, or clock stopped)
//  set = ~dly_q & i_CLK2M_STOP_DLYD_n & ~filt   (delayed restart while cold)
//  clr and set go through a one-tick pipeline (clr_d, set_d) into the FSM. Output latency: 2 ticks.
//  FSM per channel (clr_d dominates set_d when both are true):
//   OFF   : set_d -> HEAT; else stay. o_HEATEN_n=1.
//   HEAT  : clr_d -> OFF; wd==TMO-1 -> FAULT (watchdog build only); else wd++. o_HEATEN_n=0.
//   FAULT : o_HEATEN_n=1, o_FAULT=1; i_FAULT_CLR -> OFF. set_d is ignored here.
//   wd<=0 on every entry to HEAT and in OFF/FAULT. wd saturates and never wraps.
//  o_TEMPOK = &filt, registered.
//  Channels are fully independent except for the shared stop inputs and i_FAULT_CLR.
// CONFIGURATION
//  TEMPDET_WATCHDOG_EN defined: watchdog counters and FAULT state exist as described above.
//  Not defined: no wd counter and no FAULT state. HEAT leaves only on clr_d. o_FAULT is tied to 0.
//   TMO/TMO_W are unused. i_FAULT_CLR is ignored.
// TESTING (CH=2, DB_LEN=4, TMO=16, enable every 2nd MCLK)
//  ch0 TEMPLO_n 1->0 for 3 ticks, then back to 1 -> filt unchanged, no TEMPDROP pulse.
//  ch0 TEMPLO_n 1->0 held, STOP_n=1 -> filt falls after 4 ticks; TEMPDROP_SET_n[0] low exactly 1 tick.
//   ch1 stays 1, and o_TEMPOK goes to 0.
//  ch0 filt=0; STOP_n 1->0, then STOP_DLYD_n 0->1 -> HEATEN_n[0]=0 two ticks after the DLYD rise.
//   A later rise of TEMPLO_n[0] (after debounce) returns HEATEN_n[0] to 1 two ticks after filt rises.
//  Heating, STOP_n=0 on the same tick the set condition occurs -> HEATEN_n stays 1 (clear wins).
//  WATCHDOG_EN: heat 16 ticks without clear -> HEATEN_n[0]=1, FAULT[0]=1; i_FAULT_CLR pulse -> FAULT=0.
//   Without the macro: heater stays 0 indefinitely and FAULT stays 0.
//  i_RST pulse while HEATEN_n[1]=0 -> HEATEN_n[1]=1 before the next MCLK edge, and all state is at its reset value.

Source files
------------

// File: rtl/mdl_tempdet_mc.sv
// mdl_tempdet_mc: multi-channel temperature-drop detector and heater control.
// Each channel debounces its TEMPLO_n sensor, pulses TEMPDROP_SET_n on a drop of
// the gated sensor, and runs a small heater FSM driven by the 2MHz stop/restart.
// Optional build macro TEMPDET_WATCHDOG_EN adds a per-channel heater-on watchdog
// with a sticky FAULT state; without it the heater leaves HEAT only on clear.
module mdl_tempdet_mc #(
    parameter int CH     = 2,
    parameter int DB_LEN = 8,
    parameter int DB_W   = 4,
    parameter int TMO    = 50000,
    parameter int TMO_W  = 16
) (
    input  logic          i_MCLK,
    input  logic          i_RST,
    input  logic          i_CLK4M_PCEN_n,
    input  logic          i_CLK2M_STOP_n,
    input  logic          i_CLK2M_STOP_DLYD_n,
    input  logic [CH-1:0] i_TEMPLO_n,
    input  logic          i_FAULT_CLR,
    output logic [CH-1:0] o_TEMPDROP_SET_n,
    output logic [CH-1:0] o_HEATEN_n,
    output logic [CH-1:0] o_FAULT,
    output logic          o_TEMPOK
);

`ifdef TEMPDET_WATCHDOG_EN
    typedef enum logic [1:0] {ST_OFF, ST_HEAT, ST_FAULT} state_t;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO - 1);
`else
    typedef enum logic {ST_OFF, ST_HEAT} state_t;
    // Watchdog configuration and fault clear have no function in this build.
    logic unused_cfg;
    assign unused_cfg = i_FAULT_CLR ^ (TMO_W'(TMO) == '0);
`endif

    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_LEN - 1);

    logic          tick;
    logic          dly_q;
    logic          tempok_q;
    logic [CH-1:0] filt_q;

    assign tick     = ~i_CLK4M_PCEN_n;
    assign o_TEMPOK = tempok_q;

    // Shared delayed-stop history and the all-channels-warm flag.
    always_ff @(posedge i_MCLK or posedge i_RST) begin
        if (i_RST) begin
            dly_q    <= 1'b1;
            tempok_q <= 1'b1;
        end else if (tick) begin
            dly_q    <= i_CLK2M_STOP_DLYD_n;
            tempok_q <= &filt_q;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < CH; gi++) begin : g_ch
            logic [DB_W-1:0] db_cnt_q, db_cnt_d;
            logic            filt_d;
            logic            gate, gate_q;
            logic            drop_n_q;
            logic            clr, set;
            logic            clr_p_q, set_p_q;
            logic            heat_n, fault;
            state_t          state_q, state_d;
`ifdef TEMPDET_WATCHDOG_EN
            logic [TMO_W-1:0] wd_q, wd_d;
`endif

            assign gate = i_CLK2M_STOP_n & filt_q[gi];
            assign clr  = (~gate_q & gate) | ~i_CLK2M_STOP_n;
            assign set  = ~dly_q & i_CLK2M_STOP_DLYD_n & ~filt_q[gi];

            // Debounce: the filtered level follows raw only after DB_LEN differing ticks.
            always_comb begin
                db_cnt_d = '0;
                filt_d   = filt_q[gi];
                if (i_TEMPLO_n[gi] != filt_q[gi]) begin
                    if (db_cnt_q == DB_LAST) begin
                        filt_d = i_TEMPLO_n[gi];
                    end else begin
                        db_cnt_d = db_cnt_q + 1'b1;
                    end
                end
            end

            // Sensor filter, edge history, drop pulse and the clr/set pipeline stage.
            always_ff @(posedge i_MCLK or posedge i_RST) begin
                if (i_RST) begin
                    db_cnt_q   <= '0;
                    filt_q[gi] <= 1'b1;
                    gate_q     <= 1'b0;
                    drop_n_q   <= 1'b1;
                    clr_p_q    <= 1'b0;
                    set_p_q    <= 1'b0;
                end else if (tick) begin
                    db_cnt_q   <= db_cnt_d;
                    filt_q[gi] <= filt_d;
                    gate_q     <= gate;
                    drop_n_q   <= ~(gate_q & ~gate);
                    clr_p_q    <= clr;
                    set_p_q    <= set;
                end
            end

            // Heater FSM next state and Moore outputs; clear dominates set.
            always_comb begin
                state_d = state_q;
                heat_n  = 1'b1;
                fault   = 1'b0;
`ifdef TEMPDET_WATCHDOG_EN
                wd_d    = '0;
`endif
                case (state_q)
                    ST_OFF: begin
                        if (set_p_q && !clr_p_q) state_d = ST_HEAT;
                    end
                    ST_HEAT: begin
                        heat_n = 1'b0;
                        if (clr_p_q) begin
                            state_d = ST_OFF;
`ifdef TEMPDET_WATCHDOG_EN
                        end else if (wd_q == TMO_LAST) begin
                            state_d = ST_FAULT;
                        end else begin
                            wd_d = (&wd_q) ? wd_q : wd_q + 1'b1;
`endif
                        end
                    end
`ifdef TEMPDET_WATCHDOG_EN
                    ST_FAULT: begin
                        fault = 1'b1;
                        if (i_FAULT_CLR) state_d = ST_OFF;
                    end
`endif
                    default: state_d = ST_OFF;
                endcase
            end

            // Heater FSM state register (and watchdog count when built in).
            always_ff @(posedge i_MCLK or posedge i_RST) begin
                if (i_RST) begin
                    state_q <= ST_OFF;
`ifdef TEMPDET_WATCHDOG_EN
                    wd_q    <= '0;
`endif
                end else if (tick) begin
                    state_q <= state_d;
`ifdef TEMPDET_WATCHDOG_EN
                    wd_q    <= wd_d;
`endif
                end
            end

            assign o_TEMPDROP_SET_n[gi] = drop_n_q;
            assign o_HEATEN_n[gi]       = heat_n;
            assign o_FAULT[gi]          = fault;
        end
    endgenerate

endmodule
